instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Parametrised prefetch queue that replaces the single FD latch between imem and decode.
//   Issues sequential fetches to a 1-cycle-latency imem and buffers up to DEPTH {pc,insn} pairs.
//   Presents the oldest pair to decode with a valid/ready handshake.
//   Flushes all buffered and in-flight fetches on a taken-branch/jump redirect from execute.
// PARAMETERS
//   ADDR_W    32   width of PC / imem address
//   INSN_W    32   width of instruction word
//   DEPTH     4    queue entries; power of 2, >= 2
//   PC_STEP   1    increment applied to fetch PC per issued fetch (word-addressed imem)
//   RESET_PC  0    fetch PC after reset
// PORTS
//   clock          in   1        master clock; all state updates on rising edge
//   reset          in   1        asynchronous, active-low; clears all state immediately
//   imem_addr      out  ADDR_W   fetch address; valid every cycle, fetch issued when fetch_fire=1
//   fetch_fire     out  1        a fetch is issued this cycle at imem_addr
//   imem_data      in   INSN_W   instruction for address issued in the previous cycle
//   redirect_valid in   1        execute resolved a taken branch/jump/jr this cycle
//   redirect_pc    in   ADDR_W   new fetch target when redirect_valid=1
//   out_valid      out  1        head entry is valid for decode
//   out_ready      in   1        decode accepts head (low during load-use / multdiv stall)
//   out_pc         out  ADDR_W   PC+PC_STEP of head instruction (matches FD PC convention)
//   out_insn       out  INSN_W   head instruction; 0 (nop) when out_valid=0
//   count          out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//   Reset (reset=0, async): fetch_pc=RESET_PC, count=0, rd/wr ptr=0, inflight=0; out_valid=0,
//     out_insn=0, out_pc=0, fetch_fire=0, imem_addr=RESET_PC.
//   State: fetch_pc, wr_ptr, rd_ptr (log2(DEPTH) bits, wrap mod DEPTH), count, inflight flag, inflight_pc.
//   imem_addr = fetch_pc (registered).
//   fetch_fire = reset_n & !redirect_valid & (count + inflight - deq < DEPTH); deq = out_valid & out_ready.
//     Space is reserved for the in-flight response, so the queue never overflows.
//   On fetch_fire: fetch_pc <= fetch_pc + PC_STEP (wraps modulo 2^ADDR_W), inflight <= 1,
//     inflight_pc <= fetch_pc + PC_STEP; else inflight <= 0.
//   If inflight=1 and no redirect: imem_data written at wr_ptr with inflight_pc; wr_ptr++, count++.
//   Latency: fetch issued cycle N -> entry written at end of N+1 -> out_valid earliest cycle N+2.
//   Back-to-back: one fetch/cycle sustained while decode accepts every cycle (throughput 1).
//   Head: out_valid = (count!=0) & !redirect_valid; out_pc/out_insn from rd_ptr; insn forced 0 when !out_valid.
//   deq: rd_ptr++, count--. Simultaneous enqueue+dequeue: count unchanged; legal at full.
//   Empty: out_valid=0; out_ready ignored. Full: fetch_fire=0 until a dequeue frees space.
//   Redirect (priority over everything except reset):
//     - count<=0, rd_ptr<=wr_ptr<=0, inflight<=0; any response arriving next cycle is discarded.
//     - fetch_pc <= redirect_pc; first fetch of target issued the following cycle.
//     - head is masked (out_valid=0) in the redirect cycle; no dequeue occurs.
//     - redirect-to-first-target-valid: 3 cycles (redirect N, fetch N+1, out_valid N+3).
//   Redirect while out_ready=0 or queue full: same flush; stall state is irrelevant.
//   Reset asserted mid-operation: all state cleared in same instant; in-flight data discarded.
//   No combinational path from imem_data to any output; out_valid has a comb path from redirect_valid only.
// TESTING
//   Reset release, out_ready=1, imem returns addr+0x100 -> out_pc 1,2,3..., insn 0x100,0x101...; valid from cycle 2, 1/cycle.
//   out_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, fetch_fire=0, no entry lost/duplicated on release.
//   redirect_valid with redirect_pc=0x40 while full + inflight -> count=0, next head out_pc=0x41, insn of addr 0x40, stale data never shown.
//   Redirect in same cycle as out_ready=1, count=2 -> out_valid=0 that cycle, no dequeue, count=0 after.
//   fetch_pc = 2^ADDR_W-1 (ADDR_W=8) -> next fetch at 0, out_pc wraps to 0 correctly.
//   reset pulled low mid-stream for <1 cycle -> outputs cleared asynchronously, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential-fetch prefetch queue between a 1-cycle-latency imem and decode.
// Issues one fetch per cycle while space (including the in-flight response) is available,
// buffers up to DEPTH {pc, insn} pairs, and flushes everything on an execute redirect.
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   imem_addr_o      fetch address (registered fetch PC)
//   fetch_fire_o     a fetch is issued this cycle at imem_addr_o
//   imem_data_i      instruction for the address issued in the previous cycle
//   redirect_valid_i taken branch/jump resolved this cycle
//   redirect_pc_i    new fetch target
//   out_valid_o      head entry valid for decode
//   out_ready_i      decode accepts the head entry
//   out_pc_o         PC+PC_STEP of the head instruction
//   out_insn_o       head instruction, 0 when out_valid_o is low
//   count_o          occupied entries
module instr_fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSN_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    output logic [ADDR_W-1:0]          imem_addr_o,
    output logic                       fetch_fire_o,
    input  logic [INSN_W-1:0]          imem_data_i,
    input  logic                       redirect_valid_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ADDR_W-1:0]          out_pc_o,
    output logic [INSN_W-1:0]          out_insn_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INSN_W-1:0] insn_mem_q [DEPTH];

    logic              head_valid;
    logic              deq;
    logic              enq;
    logic              fire;
    logic [OCC_W-1:0]  occupancy;
    logic [ADDR_W-1:0] fetch_pc_inc;

    // Handshake and fetch-issue decisions; the in-flight response counts as occupied.
    always_comb begin
        head_valid   = (count_q != '0) && !redirect_valid_i;
        deq          = head_valid && out_ready_i;
        enq          = inflight_q && !redirect_valid_i;
        occupancy    = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(deq);
        fire         = rst_ni && !redirect_valid_i && (occupancy < OCC_W'(DEPTH));
        fetch_pc_inc = fetch_pc_q + ADDR_W'(PC_STEP);
    end

    // Next-state for fetch PC, pointers, occupancy and in-flight tracking.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;

        if (redirect_valid_i) begin
            // Flush: the response to last cycle's fetch is dropped via inflight_d=0.
            fetch_pc_d = redirect_pc_i;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fire) begin
                fetch_pc_d    = fetch_pc_inc;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_inc;
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Entry storage; cleared on reset so the head PC reads 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                insn_mem_q[i] <= '0;
            end
        end else if (enq) begin
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
            insn_mem_q[wr_ptr_q] <= imem_data_i;
        end
    end

    assign imem_addr_o  = fetch_pc_q;
    assign fetch_fire_o = fire;
    assign out_valid_o  = head_valid;
    assign out_pc_o     = pc_mem_q[rd_ptr_q];
    assign out_insn_o   = head_valid ? insn_mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue (ADDR_W=8 to exercise PC wrap, DEPTH=4).
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic        fetch_fire;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [31:0] out_insn;
    logic [2:0]  count;

    instr_fetch_queue #(
        .ADDR_W  (8),
        .INSN_W  (32),
        .DEPTH   (DEPTH),
        .PC_STEP (1),
        .RESET_PC(8'h00)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .imem_addr_o     (imem_addr),
        .fetch_fire_o    (fetch_fire),
        .imem_data_i     (imem_data),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_pc_o        (out_pc),
        .out_insn_o      (out_insn),
        .count_o         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of delivered pairs plus one pending fetch.
    typedef struct {
        logic [7:0]  pc;
        logic [31:0] insn;
    } entry_t;

    entry_t     mq[$];
    bit         pend;
    logic [7:0] pend_addr;
    logic [7:0] mpc;
    logic [7:0] prev_addr;
    logic       cur_redir;
    logic [7:0] cur_rpc;
    logic       cur_rdy;

    typedef struct {
        logic        redir;
        logic [7:0]  rpc;
        logic        rdy;
        logic        ev;
        logic [7:0]  epc;
        logic [31:0] einsn;
        logic [2:0]  ecnt;
        logic        efire;
        logic [7:0]  eaddr;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [31:0] insn_of(input logic [7:0] a);
        return 32'h100 + 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_deq();
        return (mq.size() != 0) && !cur_redir && cur_rdy;
    endfunction

    function automatic bit model_fire();
        int occ;
        occ = mq.size() + (pend ? 1 : 0) - (model_deq() ? 1 : 0);
        return !cur_redir && (occ < DEPTH);
    endfunction

    task automatic model_reset();
        mq.delete();
        pend = 1'b0;
        pend_addr = 8'h00;
        mpc = 8'h00;
    endtask

    // Apply inputs just after a rising edge, then compare against the model at the falling edge.
    task automatic drive(input logic redir, input logic [7:0] rpc, input logic rdy);
        bit ev;
        cur_redir = redir;
        cur_rpc = rpc;
        cur_rdy = rdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        out_ready = rdy;
        imem_data = insn_of(prev_addr);
        @(negedge clk);
        ev = (mq.size() != 0) && !redir;
        chk("model.valid", 32'(out_valid), 32'(ev));
        chk("model.count", 32'(count), 32'(mq.size()));
        chk("model.addr", 32'(imem_addr), 32'(mpc));
        chk("model.fire", 32'(fetch_fire), 32'(model_fire()));
        if (ev) begin
            chk("model.pc", 32'(out_pc), 32'(mq[0].pc));
            chk("model.insn", out_insn, mq[0].insn);
        end else begin
            chk("model.insn0", out_insn, 32'h0);
        end
    endtask

    // Advance the model by one clock and move to just after the next rising edge.
    task automatic advance();
        bit d;
        bit f;
        prev_addr = imem_addr;
        d = model_deq();
        f = model_fire();
        if (cur_redir) begin
            mq.delete();
            pend = 1'b0;
            mpc = cur_rpc;
        end else begin
            if (d) void'(mq.pop_front());
            if (pend) mq.push_back('{pc: pend_addr + 8'd1, insn: insn_of(pend_addr)});
            if (f) begin
                pend = 1'b1;
                pend_addr = mpc;
                mpc = mpc + 8'd1;
            end else begin
                pend = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic redir, input logic [7:0] rpc, input logic rdy);
        drive(redir, rpc, rdy);
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Startup stream, 10-cycle stall and release.
        vecs[0]  = '{0, 0, 1, 0, 8'h00, 32'h000, 3'd0, 1, 8'd0};
        vecs[1]  = '{0, 0, 1, 0, 8'h00, 32'h000, 3'd0, 1, 8'd1};
        vecs[2]  = '{0, 0, 1, 1, 8'd1,  32'h100, 3'd1, 1, 8'd2};
        vecs[3]  = '{0, 0, 1, 1, 8'd2,  32'h101, 3'd1, 1, 8'd3};
        vecs[4]  = '{0, 0, 1, 1, 8'd3,  32'h102, 3'd1, 1, 8'd4};
        vecs[5]  = '{0, 0, 0, 1, 8'd4,  32'h103, 3'd1, 1, 8'd5};
        vecs[6]  = '{0, 0, 0, 1, 8'd4,  32'h103, 3'd2, 1, 8'd6};
        vecs[7]  = '{0, 0, 0, 1, 8'd4,  32'h103, 3'd3, 0, 8'd7};
        for (int i = 8; i < 15; i++) vecs[i] = '{0, 0, 0, 1, 8'd4, 32'h103, 3'd4, 0, 8'd7};
        vecs[15] = '{0, 0, 1, 1, 8'd4,  32'h103, 3'd4, 1, 8'd7};
        vecs[16] = '{0, 0, 1, 1, 8'd5,  32'h104, 3'd3, 1, 8'd8};
        vecs[17] = '{0, 0, 1, 1, 8'd6,  32'h105, 3'd3, 1, 8'd9};
        vecs[18] = '{0, 0, 1, 1, 8'd7,  32'h106, 3'd3, 1, 8'd10};
        vecs[19] = '{0, 0, 1, 1, 8'd8,  32'h107, 3'd3, 1, 8'd11};

        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        out_ready = 1'b0;
        imem_data = 32'h0;
        prev_addr = 8'h00;
        cur_redir = 1'b0;
        cur_rpc = 8'h00;
        cur_rdy = 1'b0;
        model_reset();

        // Reset state.
        @(negedge clk);
        chk("rst.valid", 32'(out_valid), 32'h0);
        chk("rst.count", 32'(count), 32'h0);
        chk("rst.addr", 32'(imem_addr), 32'h0);
        chk("rst.fire", 32'(fetch_fire), 32'h0);
        chk("rst.insn", out_insn, 32'h0);
        chk("rst.pc", 32'(out_pc), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven startup / stall sequence.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].ecnt));
            chk($sformatf("vec%0d.fire", i), 32'(fetch_fire), 32'(vecs[i].efire));
            chk($sformatf("vec%0d.addr", i), 32'(imem_addr), 32'(vecs[i].eaddr));
            chk($sformatf("vec%0d.insn", i), out_insn, vecs[i].einsn);
            if (vecs[i].ev) chk($sformatf("vec%0d.pc", i), 32'(out_pc), 32'(vecs[i].epc));
            advance();
        end

        // Redirect while a response is in flight: it must be discarded.
        drive(1'b1, 8'h20, 1'b0);
        chk("redir_inflight.valid", 32'(out_valid), 32'h0);
        advance();
        drive(1'b0, 8'h00, 1'b0);
        chk("redir_inflight.count", 32'(count), 32'h0);
        chk("redir_inflight.addr", 32'(imem_addr), 32'h20);
        advance();

        // Fill to full, then redirect to 0x40.
        n = 0;
        while (mq.size() != DEPTH && n < 12) begin
            cyc(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("fill.count", 32'(count), 32'(DEPTH));
        drive(1'b1, 8'h40, 1'b0);
        chk("redir_full.valid", 32'(out_valid), 32'h0);
        chk("redir_full.fire", 32'(fetch_fire), 32'h0);
        advance();
        drive(1'b0, 8'h00, 1'b1);
        chk("redir_full.n1.count", 32'(count), 32'h0);
        chk("redir_full.n1.addr", 32'(imem_addr), 32'h40);
        chk("redir_full.n1.fire", 32'(fetch_fire), 32'h1);
        advance();
        drive(1'b0, 8'h00, 1'b1);
        chk("redir_full.n2.valid", 32'(out_valid), 32'h0);
        advance();
        drive(1'b0, 8'h00, 1'b1);
        chk("redir_full.n3.valid", 32'(out_valid), 32'h1);
        chk("redir_full.n3.pc", 32'(out_pc), 32'h41);
        chk("redir_full.n3.insn", out_insn, 32'h140);
        advance();

        // Redirect with decode ready and two entries queued.
        n = 0;
        while (mq.size() != 2 && n < 12) begin
            cyc(1'b0, 8'h00, 1'b0);
            n++;
        end
        drive(1'b1, 8'h80, 1'b1);
        chk("redir_rdy.count", 32'(count), 32'h2);
        chk("redir_rdy.valid", 32'(out_valid), 32'h0);
        chk("redir_rdy.insn", out_insn, 32'h0);
        advance();
        drive(1'b0, 8'h00, 1'b1);
        chk("redir_rdy.after.count", 32'(count), 32'h0);
        advance();

        // PC wrap from 0xFF to 0x00.
        cyc(1'b1, 8'hFF, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("wrap.addr_ff", 32'(imem_addr), 32'hFF);
        advance();
        drive(1'b0, 8'h00, 1'b1);
        chk("wrap.addr_00", 32'(imem_addr), 32'h00);
        advance();
        drive(1'b0, 8'h00, 1'b1);
        chk("wrap.pc0", 32'(out_pc), 32'h00);
        chk("wrap.insn0", out_insn, 32'h1FF);
        advance();
        drive(1'b0, 8'h00, 1'b1);
        chk("wrap.pc1", 32'(out_pc), 32'h01);
        chk("wrap.insn1", out_insn, 32'h100);
        advance();
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);

        // Short asynchronous reset pulse mid-stream.
        out_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(out_valid), 32'h0);
        chk("arst.count", 32'(count), 32'h0);
        chk("arst.addr", 32'(imem_addr), 32'h0);
        chk("arst.fire", 32'(fetch_fire), 32'h0);
        chk("arst.insn", out_insn, 32'h0);
        chk("arst.pc", 32'(out_pc), 32'h0);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 8'h00, 1'b1);
        chk("arst.restart.addr", 32'(imem_addr), 32'h0);
        chk("arst.restart.fire", 32'(fetch_fire), 32'h1);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            logic       r;
            logic [7:0] p;
            logic       y;
            r = ($urandom_range(0, 19) == 0);
            p = 8'($urandom_range(0, 255));
            y = ($urandom_range(0, 9) < 7);
            cyc(r, p, y);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
